prog_sequencer: RTL
===================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 The reset is Resetn, synchronous, active-low; the clock is Clock.
REQ-002 Parameter AW, default 8, SHALL set the program address width.
REQ-003 Parameter WD_LIMIT, default 7, SHALL set the maximum WAIT cycles without Done before an error is raised.
REQ-004 Ports SHALL be:
Clock  in  1  system clock
Resetn  in  1  synchronous active-low reset
Start  in  1  begin execution at StartAddr (level sampled per cycle)
Stop  in  1  request halt at next instruction boundary
StartAddr  in  AW  first program address
MemAddr  out  AW  program memory address (synchronous ROM, 1-cycle read latency)
MemData  in  16  program memory read data
DIN  out  16  instruction word to processor
Run  out  1  processor run strobe
Done  in  1  processor instruction-complete (combinational from processor)
Busy  out  1  high in FETCH, LOAD, ISSUE, WAIT
Halted  out  1  high in HALT
Error  out  1  high in ERROR
PC  out  AW  current program counter
InstrCount  out  16  instructions completed since last Start

Function
REQ-005 The FSM SHALL have states IDLE, FETCH, LOAD, ISSUE, WAIT, HALT and ERROR.
REQ-006 IDLE: on Start=1 and Stop=0 -> FETCH, PC<=StartAddr, InstrCount<=0; otherwise stay; Start with Stop in the same cycle SHALL leave the FSM in IDLE.
REQ-007 FETCH: MemAddr=PC -> LOAD next cycle.
REQ-008 LOAD: capture MemData into an internal instruction register; if MemData[15:13]=3'b111 (halt opcode) -> HALT with no issue, PC unchanged, not counted; otherwise -> ISSUE.
REQ-009 ISSUE: Run=1 and DIN=instruction register for exactly one cycle -> WAIT.
REQ-010 WAIT: Run=0; DIN SHALL hold the instruction; on Done=1 -> PC<=PC+1 (modulo 2^AW, 255 wraps to 0 for AW=8), InstrCount<=InstrCount+1 saturating at 16'hFFFF, then FETCH, or IDLE if a stop is pending.
REQ-011 A Done=1 sampled in any state other than WAIT SHALL be ignored.
REQ-012 Stop=1 in FETCH or LOAD SHALL abort to IDLE next cycle with no instruction issued; Stop=1 in ISSUE or WAIT SHALL set a stop-pending flag, cleared on entry to IDLE.
REQ-013 HALT and ERROR SHALL hold until Start=1 with Stop=0, which behaves as in IDLE (reload PC, clear InstrCount) and clears Halted/Error.
REQ-014 Start=1 while Busy SHALL be ignored.
REQ-015 MemAddr SHALL equal PC in every state; Run SHALL be 1 only in ISSUE.
REQ-016 Minimum issue interval SHALL be 4 cycles for a 1-step instruction (FETCH, LOAD, ISSUE, WAIT with Done).

Reset
REQ-017 With Resetn=0 at a clock edge: state IDLE, PC=0, InstrCount=0, DIN=0, Run=0, Busy=0, Halted=0, Error=0, stop-pending=0, watchdog=0; reset mid-instruction SHALL abandon it without a further Run.

Configuration
REQ-018 Macro PROG_SEQ_WATCHDOG_EN defined: a counter SHALL clear on entry to WAIT and increment each WAIT cycle without Done; reaching WD_LIMIT -> ERROR, with PC and InstrCount frozen.
REQ-019 Macro PROG_SEQ_WATCHDOG_EN undefined: WAIT SHALL wait indefinitely, ERROR SHALL be unreachable, and Error SHALL be tied to 0.

Verification
REQ-020 Reset, StartAddr=8'h10, Start pulse, ROM[10]=mv (Done 1 cycle after issue), ROM[11]=16'hE000 -> one Run pulse with DIN=ROM[10], then Halted=1, PC=8'h11, InstrCount=1.
REQ-021 ROM add/sub instructions with Done 3 cycles after issue -> Run pulses exactly 6 cycles apart and InstrCount increments once per Done.
REQ-022 StartAddr=8'hFF, non-halt at FF, halt at 00 -> PC wraps to 8'h00, then Halted=1.
REQ-023 Stop asserted during WAIT -> current instruction completes (PC+1, count+1), then IDLE with no further Run; Stop during FETCH -> IDLE with no Run.
REQ-024 Watchdog enabled, Done held 0 -> Error=1 after 7 WAIT cycles and Busy=0; Start -> Error=0 and execution resumes from StartAddr.
REQ-025 Resetn=0 in WAIT, then Done pulses -> outputs at reset values, no PC/count change, no Run until the next Start.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: fetches 16-bit instructions from a synchronous ROM and issues them to a processor.
// Optional watchdog on the WAIT state is enabled by defining PROG_SEQ_WATCHDOG_EN.
module prog_sequencer #(
  parameter int AW       = 8,
  parameter int WD_LIMIT = 7
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          Stop,
  input  logic [AW-1:0] StartAddr,
  output logic [AW-1:0] MemAddr,
  input  logic [15:0]   MemData,
  output logic [15:0]   DIN,
  output logic          Run,
  input  logic          Done,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [AW-1:0] PC,
  output logic [15:0]   InstrCount
);

`ifdef PROG_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam int              WDW     = (WD_LIMIT < 2) ? 1 : $clog2(WD_LIMIT + 1);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(WD_LIMIT - 1);
  localparam logic [2:0]      HALT_OP = 3'b111;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, WAIT, HALT, ERROR} state_t;

  state_t          state;
  logic [AW-1:0]   pc;
  logic [15:0]     ir;
  logic [15:0]     count;
  logic            stop_pend;
  logic [WDW-1:0]  wd;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      count     <= '0;
      stop_pend <= 1'b0;
      wd        <= '0;
    end else begin
      case (state)
        IDLE, HALT, ERROR: begin
          if (Start && !Stop) begin
            state     <= FETCH;
            pc        <= StartAddr;
            count     <= '0;
            stop_pend <= 1'b0;
          end
        end
        FETCH: begin
          if (Stop) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (Stop) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
          end else begin
            ir    <= MemData;
            state <= (MemData[15:13] == HALT_OP) ? HALT : ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
          wd    <= '0;
          if (Stop) stop_pend <= 1'b1;
        end
        WAIT: begin
          if (Done) begin
            pc    <= pc + 1'b1;
            count <= sat_inc(count);
            if (stop_pend || Stop) begin
              state     <= IDLE;
              stop_pend <= 1'b0;
            end else begin
              state <= FETCH;
            end
          end else begin
            if (Stop) stop_pend <= 1'b1;
            // Timeout freezes PC and count; only a new Start leaves ERROR.
            if (WD_EN && wd == WD_LAST) state <= ERROR;
            else if (WD_EN)             wd    <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MemAddr    = pc;
  assign PC         = pc;
  assign DIN        = ir;
  assign InstrCount = count;
  assign Run        = (state == ISSUE);
  assign Busy       = (state == FETCH) || (state == LOAD) || (state == ISSUE) || (state == WAIT);
  assign Halted     = (state == HALT);
`ifdef PROG_SEQ_WATCHDOG_EN
  assign Error      = (state == ERROR);
`else
  assign Error      = 1'b0;
`endif

endmodule
